// File: rtl/mem_stage_ctrl.sv
// Registered memory-stage control: branch/jump redirect, flush pulse, and a req/ack data-memory FSM with timeout.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses with BusErr instead of issuing them.
module mem_stage_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned WAIT_MAX     = 15,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] Instr,
   input  logic            Valid,
   input  logic            BrEq,
   input  logic            BrLT,
   input  logic [1:0]      AddrLo,
   input  logic            MemAck,
   output logic            BrUn,
   output logic            PCSel,
   output logic            MemReq,
   output logic            MemRW,
   output logic [3:0]      MemBE,
   output logic [2:0]      LdSel,
   output logic            Stall,
   output logic            Flush,
   output logic            BusErr
);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);
   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        rw_q, rw_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  ld_q, ld_d;
   logic        berr_q, berr_d;
   logic [7:0]  wait_q, wait_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic        flush_q, flush_d;

   logic [4:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store, is_branch, is_jump;
   logic        ld_legal, st_legal, mem_op;
   logic        br_taken, trap;
   logic [3:0]  be_new;
   logic        redirect;
   logic        unused_instr;

   assign opcode       = Instr[6:2];
   assign funct3       = Instr[14:12];
   assign unused_instr = ^{Instr[XLEN-1:15], Instr[11:7], Instr[1:0]};

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

   // Reserved funct3 encodings fall through as ordinary non-memory instructions.
   assign ld_legal = is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign st_legal = is_store && (funct3 inside {3'b000, 3'b001, 3'b010});
   assign mem_op   = Valid && (ld_legal || st_legal);

`ifdef MISALIGN_TRAP_EN
   assign trap = ((funct3[1:0] == 2'b01) && AddrLo[0]) ||
                 ((funct3[1:0] == 2'b10) && (AddrLo != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      be_new = 4'b1111;
      if (st_legal) begin
         unique case (funct3[1:0])
            2'b00:   be_new = 4'b0001 << AddrLo;
            2'b01:   be_new = 4'b0011 << {AddrLo[1], 1'b0};
            default: be_new = 4'b1111;
         endcase
      end
   end

   always_comb begin
      br_taken = 1'b0;
      unique case (funct3)
         3'b000:  br_taken = BrEq;
         3'b001:  br_taken = !BrEq;
         3'b100,
         3'b110:  br_taken = BrLT;
         3'b101,
         3'b111:  br_taken = !BrLT;
         default: br_taken = 1'b0;
      endcase
   end

   assign BrUn  = is_branch && funct3[2] && funct3[1];
   assign PCSel = Valid && (is_jump || (is_branch && br_taken));

   // Gated by rst_n so a reset during an access releases the pipeline immediately.
   assign Stall = rst_n && (((state_q == S_IDLE) && mem_op) || (state_q == S_ACCESS));

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rw_d    = rw_q;
      be_d    = be_q;
      ld_d    = ld_q;
      berr_d  = 1'b0;
      wait_d  = wait_q;
      unique case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               if (trap) begin
                  state_d = S_DONE;
                  berr_d  = 1'b1;
               end else begin
                  state_d = S_ACCESS;
                  req_d   = 1'b1;
                  rw_d    = st_legal;
                  be_d    = be_new;
                  ld_d    = ld_legal ? funct3 : '0;
                  wait_d  = '0;
               end
            end
         end
         S_ACCESS: begin
            if (MemAck) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               be_d    = '0;
            end else if (wait_q + 8'd1 == WAIT_LIM) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               be_d    = '0;
               berr_d  = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            wait_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign redirect = PCSel && !Stall;

   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (redirect) begin
         flush_cnt_d = FLUSH_LD;
      end else if (flush_cnt_q != '0) begin
         flush_cnt_d = flush_cnt_q - 3'd1;
      end
      flush_d = (flush_cnt_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         rw_q        <= 1'b0;
         be_q        <= '0;
         ld_q        <= '0;
         berr_q      <= 1'b0;
         wait_q      <= '0;
         flush_cnt_q <= '0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         rw_q        <= rw_d;
         be_q        <= be_d;
         ld_q        <= ld_d;
         berr_q      <= berr_d;
         wait_q      <= wait_d;
         flush_cnt_q <= flush_cnt_d;
         flush_q     <= flush_d;
      end
   end

   assign MemReq = req_q;
   assign MemRW  = rw_q;
   assign MemBE  = be_q;
   assign LdSel  = ld_q;
   assign Flush  = flush_q;
   assign BusErr = berr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed and randomized checks of mem_stage_ctrl against an instruction-semantics reference model.
module tb_mem_stage_ctrl;

   localparam int WAIT_MAX     = 15;
   localparam int FLUSH_CYCLES = 2;

   localparam logic [4:0] OPC_LD  = 5'b00000;
   localparam logic [4:0] OPC_ST  = 5'b01000;
   localparam logic [4:0] OPC_BR  = 5'b11000;
   localparam logic [4:0] OPC_JAL = 5'b11011;
   localparam logic [4:0] OPC_JR  = 5'b11001;
   localparam logic [4:0] OPC_ALU = 5'b01100;

   logic        clk, rst_n;
   logic [31:0] Instr;
   logic        Valid, BrEq, BrLT, MemAck;
   logic [1:0]  AddrLo;
   logic        BrUn, PCSel, MemReq, MemRW, Stall, Flush, BusErr;
   logic [3:0]  MemBE;
   logic [2:0]  LdSel;

   int total = 0;
   int bad   = 0;
   int flush_left = 0;
   bit exp_pc, exp_brun;

   mem_stage_ctrl #(.XLEN(32), .WAIT_MAX(WAIT_MAX), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .Valid(Valid), .BrEq(BrEq), .BrLT(BrLT),
      .AddrLo(AddrLo), .MemAck(MemAck), .BrUn(BrUn), .PCSel(PCSel), .MemReq(MemReq),
      .MemRW(MemRW), .MemBE(MemBE), .LdSel(LdSel), .Stall(Stall), .Flush(Flush), .BusErr(BusErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] f3);
      logic [31:0] r;
      r = $urandom;
      r[6:2]   = opc;
      r[14:12] = f3;
      r[1:0]   = 2'b11;
      return r;
   endfunction

   // Expected byte enables from access size and byte address.
   function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f3, input logic [1:0] a);
      int bytes, base;
      bytes = 1 << f3[1:0];
      if (!st || bytes >= 4) return 4'hF;
      base = (int'(a) / bytes) * bytes;
      return 4'(((1 << bytes) - 1) << base);
   endfunction

   // Drives one cycle of inputs; branch flags come from real operand values.
   task automatic drive(input logic [31:0] ins, input bit v, input logic [1:0] a, input bit ack,
                        input logic [31:0] r1, input logic [31:0] r2);
      logic [4:0] opc;
      logic [2:0] f3;
      bit un, t;
      opc = ins[6:2];
      f3  = ins[14:12];
      un  = (opc == OPC_BR) && (f3 >= 3'd6);
      t   = 1'b0;
      if (opc == OPC_JAL || opc == OPC_JR) t = 1'b1;
      else if (opc == OPC_BR) begin
         case (f3)
            3'd0: t = (r1 == r2);
            3'd1: t = (r1 != r2);
            3'd4: t = ($signed(r1) <  $signed(r2));
            3'd5: t = ($signed(r1) >= $signed(r2));
            3'd6: t = (r1 <  r2);
            3'd7: t = (r1 >= r2);
            default: t = 1'b0;
         endcase
      end
      Instr  = ins;
      Valid  = v;
      AddrLo = a;
      MemAck = ack;
      BrEq   = (r1 == r2);
      BrLT   = un ? (r1 < r2) : ($signed(r1) < $signed(r2));
      exp_pc   = v && t;
      exp_brun = un;
   endtask

   task automatic drv(input logic [31:0] ins, input bit v, input logic [1:0] a, input bit ack);
      logic [31:0] r1, r2;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      if ($urandom_range(0, 1) == 0) r2 = r1 + 32'($urandom_range(0, 2)) - 32'd1;
      drive(ins, v, a, ack, r1, r2);
   endtask

   // Checks all outputs for the current cycle, then advances to the next negedge.
   task automatic cyc(input bit e_req, input bit e_rw, input logic [3:0] e_be, input logic [2:0] e_ld,
                      input bit ck_ld, input bit e_stall, input bit e_berr);
      bit redir;
      #1;
      chk("MemReq", 32'(MemReq), 32'(e_req));
      if (e_req) chk("MemRW", 32'(MemRW), 32'(e_rw));
      chk("MemBE", 32'(MemBE), 32'(e_be));
      if (e_req && ck_ld) chk("LdSel", 32'(LdSel), 32'(e_ld));
      chk("Stall", 32'(Stall), 32'(e_stall));
      chk("BusErr", 32'(BusErr), 32'(e_berr));
      chk("PCSel", 32'(PCSel), 32'(exp_pc));
      chk("BrUn", 32'(BrUn), 32'(exp_brun));
      chk("Flush", 32'(Flush), 32'(flush_left != 0));
      redir = exp_pc && !e_stall;
      @(negedge clk);
      if (redir) flush_left = FLUSH_CYCLES;
      else if (flush_left > 0) flush_left--;
   endtask

   // One memory instruction; ack_after = ACCESS cycle that sees MemAck, out of range = never.
   task automatic run_mem(input logic [31:0] ins, input bit v, input logic [1:0] a, input int ack_after);
      logic [2:0] f3;
      bit st, legal, tmo;
      logic [3:0] be;
      int n;
      f3    = ins[14:12];
      st    = (ins[6:2] == OPC_ST);
      legal = st ? (f3 < 3'd3) : (f3 != 3'd3 && f3 < 3'd6);
      be    = ref_be(st, f3, a);
      drv(ins, v, a, 1'($urandom));
      if (!v || !legal) begin
         cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
         return;
      end
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0);
`ifdef MISALIGN_TRAP_EN
      if ((int'(a) % (1 << f3[1:0])) != 0) begin
         drv(ins, v, a, 1'($urandom));
         cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
         return;
      end
`endif
      tmo = !(ack_after >= 1 && ack_after <= WAIT_MAX);
      n   = tmo ? WAIT_MAX : ack_after;
      for (int k = 1; k <= n; k++) begin
         drv(ins, v, a, k == ack_after);
         cyc(1'b1, st, be, f3, !st, 1'b1, 1'b0);
      end
      drv(ins, v, a, 1'($urandom));
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, tmo);
   endtask

   initial begin
      logic [31:0] ins;
      int kind;
      rst_n = 1'b0;
      drv(mk(OPC_ALU, 3'd0), 1'b0, 2'd0, 1'b0);
      #1;
      chk("rst_MemReq", 32'(MemReq), 32'd0);
      chk("rst_MemRW", 32'(MemRW), 32'd0);
      chk("rst_MemBE", 32'(MemBE), 32'd0);
      chk("rst_LdSel", 32'(LdSel), 32'd0);
      chk("rst_Flush", 32'(Flush), 32'd0);
      chk("rst_BusErr", 32'(BusErr), 32'd0);
      chk("rst_Stall", 32'(Stall), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_mem(mk(OPC_ST, 3'b010), 1'b1, 2'd0, 3);
      run_mem(mk(OPC_ST, 3'b000), 1'b1, 2'd2, 1);
      run_mem(mk(OPC_ST, 3'b001), 1'b1, 2'd2, 1);
      run_mem(mk(OPC_LD, 3'b100), 1'b1, 2'd1, 2);

      drive(mk(OPC_BR, 3'b101), 1'b1, 2'd0, 1'b0, 32'd5, 32'd3);
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drv(mk(OPC_ALU, 3'd0), 1'b0, 2'd0, 1'b0);
         cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      end
      drive(mk(OPC_BR, 3'b110), 1'b1, 2'd0, 1'b0, 32'd5, 32'd3);
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);

      drv(mk(OPC_JAL, 3'd0), 1'b1, 2'd0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      drv(mk(OPC_JR, 3'd0), 1'b1, 2'd0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drv(mk(OPC_ALU, 3'd0), 1'b1, 2'd0, 1'b0);
         cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      end

      run_mem(mk(OPC_LD, 3'b010), 1'b1, 2'd0, 0);
      run_mem(mk(OPC_LD, 3'b010), 1'b1, 2'd0, WAIT_MAX);
      run_mem(mk(OPC_ST, 3'b001), 1'b1, 2'd3, 1);
      run_mem(mk(OPC_LD, 3'b010), 1'b1, 2'd2, 2);
      run_mem(mk(OPC_ST, 3'b011), 1'b1, 2'd0, 1);
      run_mem(mk(OPC_LD, 3'b110), 1'b1, 2'd0, 1);

      ins = mk(OPC_LD, 3'b010);
      drv(ins, 1'b1, 2'd0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      drv(ins, 1'b1, 2'd0, 1'b0);
      cyc(1'b1, 1'b0, 4'hF, 3'b010, 1'b1, 1'b1, 1'b0);
      drv(ins, 1'b1, 2'd0, 1'b0);
      #1;
      chk("acc2_MemReq", 32'(MemReq), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_MemReq", 32'(MemReq), 32'd0);
      chk("arst_Stall", 32'(Stall), 32'd0);
      chk("arst_BusErr", 32'(BusErr), 32'd0);
      @(negedge clk);
      chk("arst_hold_BusErr", 32'(BusErr), 32'd0);
      rst_n = 1'b1;
      flush_left = 0;
      run_mem(ins, 1'b1, 2'd0, 2);

      for (int it = 0; it < 300; it++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 2) begin
            drv(mk(OPC_BR, 3'($urandom)), $urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom));
            cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
         end else if (kind == 3) begin
            drv(mk(($urandom_range(0, 1) != 0) ? OPC_JAL : OPC_JR, 3'($urandom)),
                $urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom));
            cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
         end else if (kind == 4 || kind == 9) begin
            drv(mk(OPC_ALU ^ 5'($urandom_range(0, 1) << 3), 3'($urandom)),
                kind == 4, 2'($urandom), 1'($urandom));
            cyc(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
         end else begin
            run_mem(mk(($urandom_range(0, 1) != 0) ? OPC_ST : OPC_LD, 3'($urandom)),
                    $urandom_range(0, 5) != 0, 2'($urandom),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
